// File: rtl/i2c_cfg_seq_if.sv
// Handshake and register bus between the init sequencer and the I2C driver.
// The sequencer is the master; the driver (or a model of it) is the slave.
interface i2c_cfg_seq_if;
  logic        i2c_start;
  logic        wr_en;
  logic        rd_en;
  logic        addr_num;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;
  logic        i2c_end;
  logic [7:0]  rd_data;

  modport master (
    output i2c_start, wr_en, rd_en, addr_num, byte_addr, wr_data,
    input  i2c_end, rd_data
  );

  modport slave (
    input  i2c_start, wr_en, rd_en, addr_num, byte_addr, wr_data,
    output i2c_end, rd_data
  );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C register-init sequencer: walks a ROM of write / write+verify /
// delay / end entries after power-up and reports done or error with the failing index.
module i2c_cfg_seq #(
  parameter logic [15:0] CNT_PWR_MAX = 16'd1000,
  parameter logic [15:0] DELAY_UNIT  = 16'd1000,
  parameter logic [15:0] TIMEOUT_MAX = 16'd4000,
  parameter logic [1:0]  RETRY_MAX   = 2'd2,
  parameter logic [8:0]  TABLE_LEN   = 9'd256,
  parameter logic        ADDR_NUM    = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cfg_go,
  output logic [7:0]           cfg_rom_addr,
  input  logic [25:0]          cfg_rom_data,
  i2c_cfg_seq_if.master        i2c,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [7:0]           err_idx
);

  typedef enum logic [3:0] {
    S_PWR_WAIT, S_FETCH_A, S_FETCH_D, S_ISSUE, S_WAIT_WR, S_RD_ISSUE,
    S_RD_WAIT, S_COMPARE, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_WRVFY = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] byte_addr_q, byte_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_q, rd_d;
  logic [1:0]  retry_q, retry_d;
  logic [31:0] delay_tgt;

  assign delay_tgt = 32'(wr_data_q) * 32'(DELAY_UNIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_PWR_WAIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      byte_addr_q <= '0;
      wr_data_q   <= '0;
      rd_q        <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      byte_addr_q <= byte_addr_d;
      wr_data_q   <= wr_data_d;
      rd_q        <= rd_d;
      retry_q     <= retry_d;
    end
  end

  // One shared counter: it is cleared in every state that does not count, so
  // ISSUE/RD_ISSUE/FETCH_D leave it at zero for the timeout and delay states.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = '0;
    op_d        = op_q;
    byte_addr_d = byte_addr_q;
    wr_data_d   = wr_data_q;
    rd_d        = rd_q;
    retry_d     = retry_q;
    unique case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == 32'(CNT_PWR_MAX) - 32'd1) begin
          state_d = S_FETCH_A;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH_A: state_d = S_FETCH_D;
      S_FETCH_D: begin
        op_d        = cfg_rom_data[25:24];
        byte_addr_d = cfg_rom_data[23:8];
        wr_data_d   = cfg_rom_data[7:0];
        retry_d     = '0;
        if (cfg_rom_data[25:24] == OP_WRITE || cfg_rom_data[25:24] == OP_WRVFY)
          state_d = S_ISSUE;
        else if (cfg_rom_data[25:24] == OP_DELAY)
          state_d = S_DELAY;
        else
          state_d = S_DONE;
      end
      S_ISSUE: state_d = S_WAIT_WR;
      S_WAIT_WR: begin
        if (i2c.i2c_end)
          state_d = (op_q == OP_WRVFY) ? S_RD_ISSUE : S_NEXT;
        else if (cnt_q == 32'(TIMEOUT_MAX) - 32'd1)
          state_d = S_ERROR;
        else
          cnt_d = cnt_q + 32'd1;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i2c.i2c_end) begin
          rd_d    = i2c.rd_data;
          state_d = S_COMPARE;
        end else if (cnt_q == 32'(TIMEOUT_MAX) - 32'd1) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_COMPARE: begin
        if (rd_q == wr_data_q) begin
          retry_d = '0;
          state_d = S_NEXT;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 2'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_DELAY: begin
        if (cnt_q + 32'd1 >= delay_tgt)
          state_d = S_NEXT;
        else
          cnt_d = cnt_q + 32'd1;
      end
      S_NEXT: begin
        if ({1'b0, idx_q} == TABLE_LEN - 9'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH_A;
        end
      end
      S_DONE, S_ERROR: begin
        if (cfg_go) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = S_FETCH_A;
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase
  end

  assign cfg_rom_addr  = idx_q;
  assign i2c.i2c_start = (state_q == S_ISSUE) || (state_q == S_RD_ISSUE);
  assign i2c.wr_en     = (state_q == S_ISSUE) || (state_q == S_WAIT_WR);
  assign i2c.rd_en     = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
  assign i2c.addr_num  = ADDR_NUM;
  assign i2c.byte_addr = byte_addr_q;
  assign i2c.wr_data   = wr_data_q;
  assign cfg_busy      = !((state_q == S_DONE) || (state_q == S_ERROR));
  assign cfg_done      = (state_q == S_DONE);
  assign cfg_err       = (state_q == S_ERROR);
  assign err_idx       = (state_q == S_ERROR) ? idx_q : '0;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: registered ROM, an I2C driver model with a register map,
// and a table-walking reference model that predicts every transaction and the final status.
`timescale 1ns/1ps
module tb_i2c_cfg_seq;
  localparam logic [15:0] PWR  = 16'd40;
  localparam logic [15:0] DU   = 16'd10;
  localparam logic [15:0] TMO  = 16'd120;
  localparam logic [1:0]  RMAX = 2'd2;
  localparam logic [8:0]  TLEN = 9'd4;
  localparam logic        ANUM = 1'b1;
  localparam int MODE_OK = 0, MODE_BAD = 1, MODE_HANG = 2;
  localparam int BUDGET = 20000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_go = 1'b0;
  logic [7:0]  cfg_rom_addr;
  logic [25:0] cfg_rom_data;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  err_idx;

  i2c_cfg_seq_if bus ();

  i2c_cfg_seq #(
    .CNT_PWR_MAX(PWR), .DELAY_UNIT(DU), .TIMEOUT_MAX(TMO),
    .RETRY_MAX(RMAX), .TABLE_LEN(TLEN), .ADDR_NUM(ANUM)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_go(cfg_go),
    .cfg_rom_addr(cfg_rom_addr), .cfg_rom_data(cfg_rom_data),
    .i2c(bus),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 sys_clk = ~sys_clk;

  logic [25:0] rom [4];
  always @(posedge sys_clk) cfg_rom_data <= rom[cfg_rom_addr[1:0]];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed { logic rd; logic [15:0] a; logic [7:0] d; } txn_t;
  txn_t obs_q[$], exp_q[$];
  int   st_q[$], end_q[$];
  bit   stab_q[$];
  int   mode = MODE_OK;
  int   lat_lo = 2, lat_hi = 40;
  logic [7:0] bad_mask = 8'h00;
  logic [7:0] regmap [logic [15:0]];
  int   checks = 0, errors = 0;
  bit   exp_done, exp_err;
  int   exp_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver model: accepts a start, holds for a random latency, pulses i2c_end.
  initial begin
    txn_t t;
    bit   ok, abort;
    int   lat;
    bus.i2c_end = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge sys_clk);
      bus.i2c_end = 1'b0;
      if (sys_rst_n && bus.i2c_start) begin
        t = '{rd: bus.rd_en, a: bus.byte_addr, d: bus.wr_data};
        obs_q.push_back(t);
        st_q.push_back(cyc);
        ok = (bus.wr_en != bus.rd_en);
        abort = 1'b0;
        if (mode != MODE_HANG) begin
          lat = $urandom_range(lat_hi, lat_lo);
          for (int k = 1; k < lat; k++) begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
              abort = 1'b1;
              break;
            end
            if (bus.i2c_start || bus.byte_addr !== t.a || bus.wr_data !== t.d ||
                bus.rd_en !== t.rd || bus.wr_en !== !t.rd)
              ok = 1'b0;
          end
          if (!abort) begin
            if (!t.rd) regmap[t.a] = t.d;
            bus.rd_data = t.rd ? ((regmap.exists(t.a) ? regmap[t.a] : 8'h00) ^
                                  ((mode == MODE_BAD) ? bad_mask : 8'h00)) : 8'h00;
            bus.i2c_end = 1'b1;
            end_q.push_back(cyc);
            stab_q.push_back(ok);
          end
        end
      end
    end
  end

  // Reference: walk the table by opcode rules, listing the expected transactions.
  task automatic ref_run();
    logic [1:0] op;
    txn_t w;
    int tries;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < int'(TLEN); i++) begin
      op = rom[i][25:24];
      w  = '{rd: 1'b0, a: rom[i][23:8], d: rom[i][7:0]};
      if (op == 2'b11) begin
        exp_done = 1'b1;
        return;
      end
      if (op[1] == 1'b0) begin
        tries = (op == 2'b01) ? int'(RMAX) + 1 : 1;
        for (int t = 0; t < tries; t++) begin
          exp_q.push_back(w);
          if (mode == MODE_HANG) begin
            exp_err = 1'b1;
            exp_idx = i;
            return;
          end
          if (op == 2'b01) begin
            exp_q.push_back('{rd: 1'b1, a: w.a, d: w.d});
            if (mode == MODE_OK) break;
            if (t == tries - 1) begin
              exp_err = 1'b1;
              exp_idx = i;
              return;
            end
          end
        end
      end
    end
    exp_done = 1'b1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rom_addr"}, cfg_rom_addr, 0);
    check({tag, "_start"},    bus.i2c_start, 0);
    check({tag, "_wr_en"},    bus.wr_en, 0);
    check({tag, "_rd_en"},    bus.rd_en, 0);
    check({tag, "_addr_num"}, bus.addr_num, ANUM);
    check({tag, "_byte_addr"}, bus.byte_addr, 0);
    check({tag, "_wr_data"},  bus.wr_data, 0);
    check({tag, "_busy"},     cfg_busy, 1);
    check({tag, "_done"},     cfg_done, 0);
    check({tag, "_err"},      cfg_err, 0);
    check({tag, "_err_idx"},  err_idx, 0);
  endtask

  // Launches one pass (reset or cfg_go) and waits, bounded, for done/error.
  task automatic run(input bit use_reset, output int t0);
    int n;
    obs_q.delete(); st_q.delete(); end_q.delete(); stab_q.delete(); regmap.delete();
    @(negedge sys_clk);
    if (use_reset) begin
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      t0 = cyc;
      // cfg_go during the power wait must be ignored
      repeat (5) @(negedge sys_clk);
      cfg_go = 1'b1;
      @(negedge sys_clk);
      cfg_go = 1'b0;
    end else begin
      cfg_go = 1'b1;
      t0 = cyc;
      @(negedge sys_clk);
      cfg_go = 1'b0;
    end
    n = 0;
    while (!(cfg_done || cfg_err) && n < BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("finish_in_budget", (n < BUDGET), 1);
  endtask

  task automatic compare_run(input string tag);
    int ns;
    ref_run();
    check({tag, "_done"},    cfg_done, exp_done);
    check({tag, "_err"},     cfg_err, exp_err);
    check({tag, "_err_idx"}, err_idx, exp_err ? exp_idx : 0);
    check({tag, "_busy"},    cfg_busy, 0);
    ns = st_q.size();
    repeat (30) @(negedge sys_clk);
    check({tag, "_no_start_after"}, st_q.size(), ns);
    check({tag, "_ntxn"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    foreach (stab_q[i]) check($sformatf("%s_stable%0d", tag, i), stab_q[i], 1);
  endtask

  initial begin
    int t0, lat, gap, expv, n;
    logic [1:0] op;

    rom[0] = {2'b00, 16'h0012, 8'h80};
    rom[1] = {2'b00, 16'h003D, 8'h03};
    rom[2] = {2'b11, 24'h0};
    rom[3] = {2'b00, 16'hBEEF, 8'h55};
    repeat (3) @(negedge sys_clk);
    reset_checks("rst");

    // Basic two-write table from power-up; cycle 1 is the one in which reset releases.
    run(1'b1, t0);
    check("first_start_cycle", (st_q.size() > 0) ? st_q[0] - t0 + 1 : -1, 32'(PWR) + 3);
    compare_run("tbl1");

    // Write+verify, readback matches.
    rom[0] = {2'b01, 16'h000C, 8'h10};
    rom[1] = {2'b11, 24'h0};
    run(1'b0, t0);
    check("go_latency", (st_q.size() > 0) ? st_q[0] - t0 : -1, 3);
    compare_run("vfy_ok");

    // Readback always 0x00: rewrite RMAX times, then error at index 0.
    mode = MODE_BAD;
    bad_mask = 8'h10;
    run(1'b0, t0);
    compare_run("vfy_bad");

    // Driver never completes: timeout, then restart without power wait.
    rom[0] = {2'b00, 16'h0022, 8'h44};
    mode = MODE_HANG;
    run(1'b0, t0);
    lat = (st_q.size() > 0) ? cyc - st_q[st_q.size() - 1] : -1;
    check("tmo_latency", (lat == int'(TMO) || lat == int'(TMO) + 1) ? int'(TMO) : lat, 32'(TMO));
    compare_run("tmo");
    mode = MODE_OK;
    run(1'b0, t0);
    check("go_after_err_latency", (st_q.size() > 0) ? st_q[0] - t0 : -1, 3);
    compare_run("tmo_restart");

    // Delay of 5 units between two writes; each entry costs NEXT + FETCH x2 + issue/decode.
    rom[0] = {2'b00, 16'h0001, 8'hA1};
    rom[1] = {2'b10, 16'h0000, 8'h05};
    rom[2] = {2'b00, 16'h0002, 8'hA2};
    rom[3] = {2'b11, 24'h0};
    run(1'b0, t0);
    gap  = (st_q.size() > 1 && end_q.size() > 0) ? st_q[1] - end_q[0] : -1;
    expv = 5 * int'(DU) + 8;
    check("delay_gap", (gap >= expv - 2 && gap <= expv + 2) ? expv : gap, expv);
    compare_run("delay");

    // Reset while a write is outstanding, then a table without END (TABLE_LEN=4).
    rom[0] = {2'b00, 16'h1111, 8'h01};
    rom[1] = {2'b00, 16'h2222, 8'h02};
    rom[2] = {2'b00, 16'h3333, 8'h03};
    rom[3] = {2'b00, 16'h4444, 8'h04};
    lat_lo = 30; lat_hi = 30;
    @(negedge sys_clk);
    cfg_go = 1'b1;
    @(negedge sys_clk);
    cfg_go = 1'b0;
    n = 0;
    while (!bus.i2c_start && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("mid_start_seen", (n < 100), 1);
    repeat (3) @(negedge sys_clk);
    check("mid_in_wait_wr", bus.wr_en, 1);
    sys_rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    lat_lo = 2; lat_hi = 40;
    run(1'b1, t0);
    check("mid_first_start_cycle", (st_q.size() > 0) ? st_q[0] - t0 + 1 : -1, 32'(PWR) + 3);
    compare_run("no_end");

    // Randomized tables, readback behaviour, latencies and launch method.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) begin
        op = 2'($urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 2) == 0 ? 2 : 1));
        if ($urandom_range(0, 9) == 0) op = 2'b11;
        rom[i] = {op, 16'($urandom), (op == 2'b10) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
      end
      n = $urandom_range(0, 9);
      mode = (n < 5) ? MODE_OK : ((n < 9) ? MODE_BAD : MODE_HANG);
      bad_mask = 8'($urandom_range(1, 255));
      lat_hi = $urandom_range(2, 50);
      lat_lo = $urandom_range(2, lat_hi);
      run(1'($urandom_range(0, 1)), t0);
      compare_run($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
